// File: rtl/rx_232.sv
// rx_232: RS-232 serial receiver for the UART link.
// Oversamples the asynchronous RXD line with CLK and validates the start bit at mid-bit.
// It shifts in 8 data bits LSB-first, then checks the stop bit.
// A good byte is presented on DATA with a one-cycle RDY pulse.
// Optional feature: define RX_PARITY_EN for 8E1 frames. A PARITY state follows DATA,
// and PERR flags an even-parity mismatch together with RDY. Default build is 8N1 with PERR tied low.
// Handshake: RDY, FERR and PERR are single-cycle pulses with no back-pressure. The consumer must
// capture DATA in the cycle RDY is high. DATA then holds until the next good frame or reset.
module rx_232 #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       RDY,
    output logic       FERR,
    output logic       PERR,
    output logic       EOR,
    output logic [2:0] state_dbg
);

    // Counter wide enough to hold CLKS_PER_BIT-1.
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF   = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BRK    = 3'd5
    } state_t;

    logic          rxd_meta;
    logic          rxs;
    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [7:0]    shr;
    logic [7:0]    shr_nx;
    logic [2:0]    idx;
    logic [2:0]    idx_nx;
    logic [7:0]    data_nx;
    logic          rdy_nx;
    logic          ferr_nx;
    logic          perr_nx;
    logic          eor_nx;
    logic          tick;
`ifdef RX_PARITY_EN
    logic          par;
    logic          par_nx;
`endif

    assign state_dbg = state;

    // Two-flop synchronizer on the asynchronous line; both stages idle high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rxd_meta <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            rxd_meta <= RXD;
            rxs      <= rxd_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic, bit timing, shifting and output pulse generation.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shr_nx   = shr;
        idx_nx   = idx;
        data_nx  = DATA;
        rdy_nx   = 1'b0;
        ferr_nx  = 1'b0;
        perr_nx  = 1'b0;
`ifdef RX_PARITY_EN
        par_nx   = par;
`endif
        tick     = (cnt == '0);

        // While a frame is in progress the counter free-runs one bit period per sample.
        if (state != S_IDLE && state != S_BRK) begin
            cnt_nx = tick ? CNT_RELOAD : cnt - 1'b1;
        end

        case (state)
            S_IDLE: begin
                // A low line starts a half-bit wait so later samples land mid-bit.
                if (!rxs) begin
                    state_nx = S_START;
                    cnt_nx   = CNT_HALF;
                end
            end
            S_START: begin
                // Line back high at mid-start-bit is a glitch; drop it silently.
                if (tick) begin
                    if (!rxs) begin
                        state_nx = S_DATA;
                        idx_nx   = 3'd0;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shr_nx = {rxs, shr[7:1]};
                    idx_nx = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef RX_PARITY_EN
                        state_nx = S_PARITY;
`else
                        state_nx = S_STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    par_nx   = rxs;
                    state_nx = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Returning to IDLE at mid-stop-bit leaves half a bit of margin
                // for a back-to-back start bit.
                if (tick) begin
                    if (rxs) begin
                        data_nx  = shr;
                        rdy_nx   = 1'b1;
`ifdef RX_PARITY_EN
                        perr_nx  = ^{shr, par};
`endif
                        state_nx = S_IDLE;
                    end else begin
                        ferr_nx  = 1'b1;
                        state_nx = S_BRK;
                    end
                end
            end
            S_BRK: begin
                // A held-low line (break) must not look like a new start bit.
                if (rxs) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // EOR drops one edge after the start is seen and rises on the edge that returns to IDLE.
        eor_nx = (state == S_IDLE) || (state_nx == S_IDLE);
    end

    // Datapath and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt  <= '0;
            shr  <= 8'h00;
            idx  <= 3'd0;
            DATA <= 8'h00;
            RDY  <= 1'b0;
            FERR <= 1'b0;
            PERR <= 1'b0;
            EOR  <= 1'b1;
`ifdef RX_PARITY_EN
            par  <= 1'b0;
`endif
        end else begin
            cnt  <= cnt_nx;
            shr  <= shr_nx;
            idx  <= idx_nx;
            DATA <= data_nx;
            RDY  <= rdy_nx;
            FERR <= ferr_nx;
            PERR <= perr_nx;
            EOR  <= eor_nx;
`ifdef RX_PARITY_EN
            par  <= par_nx;
`endif
        end
    end

endmodule
